// File: rtl/namuru_dump_sched.sv
// Correlator dump scheduler: on each accepted accumulation strobe, walks the
// pending tracking channels in ascending order, reads six correlator words per
// channel through the shared readout mux and writes them into the result
// buffer. Keeps sticky per-channel fresh/missed flags and a sticky overrun flag.
module namuru_dump_sched #(
    parameter int NCH = 4
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            accum_pulse,
    input  logic [NCH-1:0]  ch_dump,
    output logic [2:0]      ch_sel,
    output logic [2:0]      word_sel,
    input  logic [15:0]     corr_data,
    output logic            buf_we,
    output logic [5:0]      buf_adr,
    output logic [15:0]     buf_dat,
    output logic [NCH-1:0]  new_data,
    output logic [NCH-1:0]  missed,
    input  logic            clr_we,
    input  logic [NCH-1:0]  clr_mask,
    input  logic            clr_ovr,
    output logic            busy,
    output logic            done_irq,
    output logic            overrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_LAST = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0] LAST_WORD = 3'd5;

    state_t          state_r, state_n;
    logic [NCH-1:0]  pend_r, pend_n, pend_left_s, ch_onehot_s;
    logic [2:0]      ch_r, ch_n, word_r, word_n;
    logic            busy_r, done_r;
    logic            we_r, wr_live_s;
    logic [5:0]      adr_r;
    logic [15:0]     dat_hold_r;
    logic [NCH-1:0]  new_data_r, new_data_n, missed_r, missed_n;
    logic [NCH-1:0]  set_s, clr_s;
    logic            overrun_r, overrun_n;

    // Index of the lowest set bit; channels are always served lowest first.
    function automatic logic [2:0] lowest_idx(input logic [NCH-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // One-hot of the channel currently being read.
    always_comb begin
        ch_onehot_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            ch_onehot_s[i] = (ch_r == 3'(i));
        end
    end

    // Scan FSM next-state and channel/word sequencing.
    always_comb begin
        state_n     = state_r;
        pend_n      = pend_r;
        ch_n        = ch_r;
        word_n      = word_r;
        pend_left_s = pend_r & ~ch_onehot_s;
        case (state_r)
            ST_IDLE: begin
                if (accum_pulse && (ch_dump != {NCH{1'b0}})) begin
                    pend_n  = ch_dump;
                    ch_n    = lowest_idx(ch_dump);
                    word_n  = 3'd0;
                    state_n = ST_READ;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_READ: begin
                if (word_r == LAST_WORD) begin
                    state_n = ST_LAST;
                end else begin
                    word_n = word_r + 3'd1;
                end
            end
            ST_LAST: begin
                pend_n = pend_left_s;
                if (pend_left_s != {NCH{1'b0}}) begin
                    ch_n    = lowest_idx(pend_left_s);
                    word_n  = 3'd0;
                    state_n = ST_READ;
                end else begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Sticky flags: a LAST-cycle set beats a software clear of the same bit,
    // and an overrun set beats clr_ovr.
    always_comb begin
        set_s = (state_r == ST_LAST) ? ch_onehot_s : {NCH{1'b0}};
        clr_s = clr_we ? clr_mask : {NCH{1'b0}};
        new_data_n = (new_data_r & ~clr_s) | set_s;
        missed_n   = (missed_r & ~clr_s) | (set_s & new_data_r & ~clr_s);
        if (accum_pulse && (state_r != ST_IDLE)) begin
            overrun_n = 1'b1;
        end else if (clr_ovr) begin
            overrun_n = 1'b0;
        end else begin
            overrun_n = overrun_r;
        end
    end

    // FSM state, sequencing registers and registered status outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r <= ST_IDLE;
            pend_r  <= {NCH{1'b0}};
            ch_r    <= 3'd0;
            word_r  <= 3'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            pend_r  <= pend_n;
            ch_r    <= ch_n;
            word_r  <= word_n;
            busy_r  <= (state_n != ST_IDLE);
            done_r  <= (state_n == ST_DONE);
        end
    end

    // Write pipeline (mux has one cycle of latency) and sticky flag registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            we_r       <= 1'b0;
            adr_r      <= 6'd0;
            dat_hold_r <= 16'd0;
            new_data_r <= {NCH{1'b0}};
            missed_r   <= {NCH{1'b0}};
            overrun_r  <= 1'b0;
        end else begin
            we_r <= (state_r == ST_READ);
            if (state_r == ST_READ) begin
                adr_r <= {ch_r, word_r};
            end
            if (we_r) begin
                dat_hold_r <= corr_data;
            end
            new_data_r <= new_data_n;
            missed_r   <= missed_n;
            overrun_r  <= overrun_n;
        end
    end

    // Write data arrives from the mux in the write cycle itself, so it is
    // passed straight through while writing and held afterwards. Reset kills
    // a write already in flight.
    assign wr_live_s = we_r & ~sys_rst;
    assign buf_we    = wr_live_s;
    assign buf_adr   = adr_r;
    assign buf_dat   = wr_live_s ? corr_data : dat_hold_r;
    assign ch_sel    = ch_r;
    assign word_sel  = word_r;
    assign new_data  = new_data_r;
    assign missed    = missed_r;
    assign busy      = busy_r;
    assign done_irq  = done_r;
    assign overrun   = overrun_r;

endmodule
